// File: rtl/dispense_controller_if.sv
// Bundle of user-input, counter and valve-side signals for the dispense controller.
// The controller connects through the slave modport; the environment connects through master.
interface dispense_controller_if #(
  parameter int unsigned BIT_COUNT = 32
);
  logic                 request;
  logic                 cup_present;
  logic [BIT_COUNT-1:0] count;
  logic                 counter_clear;
  logic                 valve_open;
  logic                 busy;
  logic                 done;
  logic                 aborted;

  modport master (
    output request, cup_present, count,
    input  counter_clear, valve_open, busy, done, aborted
  );

  modport slave (
    input  request, cup_present, count,
    output counter_clear, valve_open, busy, done, aborted
  );
endinterface

// File: rtl/dispense_controller.sv
// Water dispenser valve controller: opens the valve for DISPENSE_COUNT cycles of the external
// counter. Define DISPENSE_COOLDOWN_EN to add a COOLDOWN_COUNT-cycle lockout after each dispense.
module dispense_controller #(
  parameter int unsigned          BIT_COUNT      = 32,
  parameter logic [BIT_COUNT-1:0] DISPENSE_COUNT = 18
`ifdef DISPENSE_COOLDOWN_EN
  ,
  parameter logic [BIT_COUNT-1:0] COOLDOWN_COUNT = 8
`endif
) (
  input logic                  clock,
  input logic                  reset,
  dispense_controller_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DISPENSE = 3'd1;
  localparam logic [2:0] DONE     = 3'd2;
  localparam logic [2:0] ABORT    = 3'd3;
`ifdef DISPENSE_COOLDOWN_EN
  localparam logic [2:0] COOLDOWN = 3'd4;
  localparam logic [BIT_COUNT-1:0] COOLDOWN_LAST = COOLDOWN_COUNT - BIT_COUNT'(1);
`endif

  // The counter reads 0 in the first DISPENSE cycle, so the last open cycle sees COUNT-1.
  localparam logic [BIT_COUNT-1:0] DISPENSE_LAST = DISPENSE_COUNT - BIT_COUNT'(1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic       request_prev;
  logic       start;
  logic       clear_next;
  logic       valve_next;
  logic       busy_next;
  logic       done_next;
  logic       aborted_next;

  assign start = bus.request & ~request_prev & bus.cup_present;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = DISPENSE;
      DISPENSE: begin
        // Cup removal wins over a coincident completion.
        if (!bus.cup_present)                state_next = ABORT;
        else if (bus.count >= DISPENSE_LAST) state_next = DONE;
      end
`ifdef DISPENSE_COOLDOWN_EN
      DONE:     state_next = COOLDOWN;
      COOLDOWN: if (bus.count >= COOLDOWN_LAST) state_next = IDLE;
`else
      DONE:     state_next = IDLE;
`endif
      ABORT:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    clear_next   = 1'b1;
    valve_next   = 1'b0;
    busy_next    = 1'b1;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    case (state_next)
      IDLE:     busy_next    = 1'b0;
      DISPENSE: begin
        clear_next = 1'b0;
        valve_next = 1'b1;
      end
      DONE:     done_next    = 1'b1;
      ABORT:    aborted_next = 1'b1;
`ifdef DISPENSE_COOLDOWN_EN
      COOLDOWN: clear_next   = 1'b0;
`endif
      default:  busy_next    = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      request_prev      <= 1'b1;
      bus.counter_clear <= 1'b1;
      bus.valve_open    <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.aborted       <= 1'b0;
    end else begin
      state             <= state_next;
      request_prev      <= bus.request;
      bus.counter_clear <= clear_next;
      bus.valve_open    <= valve_next;
      bus.busy          <= busy_next;
      bus.done          <= done_next;
      bus.aborted       <= aborted_next;
    end
  end

endmodule

// File: tb/tb_dispense_controller.sv
// Scoreboard bench for dispense_controller: stimulus queues expected valve runs, a monitor
// checks each valve fall / done / aborted event. Define DISPENSE_COOLDOWN_EN for the lockout test.
module tb_dispense_controller;

  typedef struct packed {
    logic        done;
    logic        aborted;
    logic [31:0] len;
    logic [31:0] first_cnt;
    logic [31:0] last_cnt;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];

  dispense_controller_if #(.BIT_COUNT(32)) bus ();

  dispense_controller #(
    .BIT_COUNT      (32),
    .DISPENSE_COUNT (32'd18)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Free-running counter with synchronous active-high clear.
  initial bus.count = '0;
  always @(posedge clock) begin
    if (bus.counter_clear) bus.count <= '0;
    else                   bus.count <= bus.count + 32'd1;
  end

  // Monitor: one event per valve fall or done/aborted pulse, compared against the queue.
  logic [31:0] run_len    = '0;
  logic [31:0] first_cnt  = '0;
  logic [31:0] last_cnt   = '0;
  logic        prev_valve = 1'b0;
  ev_t         obs;
  ev_t         exp_ev;

  always @(negedge clock) begin
    if (bus.valve_open === 1'b1) begin
      if (run_len == 0) first_cnt = bus.count;
      last_cnt = bus.count;
      run_len  = run_len + 32'd1;
    end
    if ((prev_valve && bus.valve_open !== 1'b1) || bus.done === 1'b1 || bus.aborted === 1'b1) begin
      obs.done      = bus.done;
      obs.aborted   = bus.aborted;
      obs.len       = run_len;
      obs.first_cnt = first_cnt;
      obs.last_cnt  = last_cnt;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got done=%0b aborted=%0b len=%0d, required no event",
                 obs.done, obs.aborted, obs.len);
      end else begin
        exp_ev = exp_q.pop_front();
        if (obs !== exp_ev) begin
          fails++;
          $display("FAIL scoreboard: got done=%0b aborted=%0b len=%0d first=%0d last=%0d, required done=%0b aborted=%0b len=%0d first=%0d last=%0d",
                   obs.done, obs.aborted, obs.len, obs.first_cnt, obs.last_cnt,
                   exp_ev.done, exp_ev.aborted, exp_ev.len, exp_ev.first_cnt, exp_ev.last_cnt);
        end
      end
      run_len = '0;
    end
    prev_valve = (bus.valve_open === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic d, input logic a, input int len, input int last);
    ev_t e;
    e.done      = d;
    e.aborted   = a;
    e.len       = 32'(len);
    e.first_cnt = '0;
    e.last_cnt  = 32'(last);
    exp_q.push_back(e);
  endtask

  initial begin
    bus.request     = 1'b1;
    bus.cup_present = 1'b1;
    reset           = 1'b0;
    tick(3);
    check("rst_valve",   {31'd0, bus.valve_open},    32'd0);
    check("rst_clear",   {31'd0, bus.counter_clear}, 32'd1);
    check("rst_busy",    {31'd0, bus.busy},          32'd0);
    check("rst_done",    {31'd0, bus.done},          32'd0);
    check("rst_aborted", {31'd0, bus.aborted},       32'd0);

    // Held button across reset release must not dispense.
    reset = 1'b1;
    tick(5);
    check("held_valve", {31'd0, bus.valve_open},    32'd0);
    check("held_busy",  {31'd0, bus.busy},          32'd0);
    check("held_clear", {31'd0, bus.counter_clear}, 32'd1);
    bus.request = 1'b0;
    tick(2);

    // Normal dispense.
    bus.request = 1'b1;
    push_exp(1'b1, 1'b0, 18, 17);
    tick(1);
    check("disp_valve", {31'd0, bus.valve_open},    32'd1);
    check("disp_busy",  {31'd0, bus.busy},          32'd1);
    check("disp_clear", {31'd0, bus.counter_clear}, 32'd0);
    tick(17);
    check("disp_last_valve", {31'd0, bus.valve_open}, 32'd1);
    tick(1);
    check("done_pulse", {31'd0, bus.done},          32'd1);
    check("done_valve", {31'd0, bus.valve_open},    32'd0);
    check("done_clear", {31'd0, bus.counter_clear}, 32'd1);
    bus.request = 1'b0;
    tick(1);
    check("after_done_count", bus.count, 32'd0);
`ifdef DISPENSE_COOLDOWN_EN
    // Lockout: requests and cup removal ignored, then a fresh request is accepted.
    check("cool_busy_first",  {31'd0, bus.busy},          32'd1);
    check("cool_valve",       {31'd0, bus.valve_open},    32'd0);
    check("cool_clear",       {31'd0, bus.counter_clear}, 32'd0);
    tick(3);
    bus.cup_present = 1'b0;
    bus.request     = 1'b1;
    tick(4);
    check("cool_busy_last",   {31'd0, bus.busy},       32'd1);
    check("cool_valve_last",  {31'd0, bus.valve_open}, 32'd0);
    tick(1);
    check("cool_busy_clear",  {31'd0, bus.busy},       32'd0);
    bus.cup_present = 1'b1;
    bus.request     = 1'b0;
    tick(1);
    bus.request = 1'b1;
    push_exp(1'b1, 1'b0, 18, 17);
    tick(1);
    check("cool_restart_valve", {31'd0, bus.valve_open}, 32'd1);
    tick(18);
    bus.request = 1'b0;
    tick(12);
`else
    // Request in the cycle right after DONE is accepted.
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.request = 1'b1;
    push_exp(1'b1, 1'b0, 18, 17);
    tick(1);
    check("b2b_valve", {31'd0, bus.valve_open}, 32'd1);
    tick(18);
    check("b2b_done", {31'd0, bus.done}, 32'd1);
    bus.request = 1'b0;
    tick(2);
`endif

    // Cup removed during DISPENSE cycle 5.
    bus.request = 1'b1;
    push_exp(1'b0, 1'b1, 6, 5);
    tick(6);
    bus.cup_present = 1'b0;
    tick(1);
    check("abort_pulse", {31'd0, bus.aborted},       32'd1);
    check("abort_done",  {31'd0, bus.done},          32'd0);
    check("abort_valve", {31'd0, bus.valve_open},    32'd0);
    check("abort_clear", {31'd0, bus.counter_clear}, 32'd1);
    tick(1);
    check("abort_idle_busy",  {31'd0, bus.busy}, 32'd0);
    check("abort_idle_count", bus.count,         32'd0);
    bus.request = 1'b0;
    tick(2);

    // Request edge without a cup is ignored.
    bus.request = 1'b1;
    tick(3);
    check("nocup_valve", {31'd0, bus.valve_open}, 32'd0);
    check("nocup_busy",  {31'd0, bus.busy},       32'd0);
    bus.request     = 1'b0;
    bus.cup_present = 1'b1;
    tick(2);

    // Second request edge at DISPENSE cycle 10 is ignored.
    bus.request = 1'b1;
    push_exp(1'b1, 1'b0, 18, 17);
    tick(9);
    bus.request = 1'b0;
    tick(2);
    bus.request = 1'b1;
    tick(8);
    check("retrig_done", {31'd0, bus.done}, 32'd1);
    bus.request = 1'b0;
    tick(14);
    check("retrig_idle", {31'd0, bus.valve_open}, 32'd0);

    // Reset asserted at DISPENSE cycle 7.
    bus.request = 1'b1;
    push_exp(1'b0, 1'b0, 8, 7);
    tick(8);
    reset = 1'b0;
    tick(1);
    check("mid_rst_valve",   {31'd0, bus.valve_open},    32'd0);
    check("mid_rst_clear",   {31'd0, bus.counter_clear}, 32'd1);
    check("mid_rst_done",    {31'd0, bus.done},          32'd0);
    check("mid_rst_aborted", {31'd0, bus.aborted},       32'd0);
    reset       = 1'b1;
    bus.request = 1'b0;
    tick(3);
    check("post_rst_busy",  {31'd0, bus.busy},       32'd0);
    check("post_rst_valve", {31'd0, bus.valve_open}, 32'd0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dispense_controller.md
Name: dispense_controller

Overview:
- Consumer and controller for the free-running `counter` block in the water dispenser.
- Drives the counter's active-high clear input and watches its `count` output.
- Opens the water valve for exactly DISPENSE_COUNT clock cycles per request, then clears the counter and reports completion.
- Sits between the user inputs (request button, cup sensor) and the valve driver.

Parameters:
- BIT_COUNT, 32, width of the `count` input; matches the counter instance.
- DISPENSE_COUNT, 18, valve-open duration in clock cycles (360 ns at a 20 ns clock); legal range 1..2^BIT_COUNT-1.
- COOLDOWN_COUNT, 8, lockout duration in clock cycles after a completed dispense; used only with DISPENSE_COOLDOWN_EN.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- request  input  1  dispense button level, already synchronised upstream.
- cup_present  input  1  cup sensor; 1 = cup in place.
- count  input  BIT_COUNT  current value from the counter.
- counter_clear  output  1  active-high clear to the counter's reset input.
- valve_open  output  1  1 = water flowing.
- busy  output  1  1 = not accepting requests.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse when a dispense is cut short.

Behaviour:
- Sampling: all outputs are registered (Moore). reset is sampled only at the clock edge; reset=0 at an edge forces the reset state.
- Reset values:
  - state=IDLE, request_prev=1 (a held button does not start a dispense on reset release).
  - counter_clear=1, valve_open=0, busy=0, done=0, aborted=0.
- Edge detect: start = request & ~request_prev & cup_present, evaluated at the edge. request_prev updates every cycle.
- States and outputs:
  - IDLE: counter_clear=1, valve_open=0, busy=0.
  - DISPENSE: counter_clear=0, valve_open=1, busy=1.
  - DONE: counter_clear=1, valve_open=0, busy=1, done=1.
  - ABORT: counter_clear=1, valve_open=0, busy=1, aborted=1.
  - COOLDOWN (optional): counter_clear=0, valve_open=0, busy=1.
- Transitions:
  - IDLE -> DISPENSE on start.
  - DISPENSE -> ABORT if cup_present=0. This has priority over completion.
  - DISPENSE -> DONE when count >= DISPENSE_COUNT-1.
  - DONE -> IDLE, or -> COOLDOWN when the feature is enabled.
  - ABORT -> IDLE unconditionally.
  - COOLDOWN -> IDLE when count >= COOLDOWN_COUNT-1.
- Timing guarantee: the counter is held at 0 in IDLE, so count=0 in the first DISPENSE cycle. valve_open is therefore high for exactly DISPENSE_COUNT consecutive cycles.
- Latency: rising request sampled at edge k -> valve_open=1 from edge k through edge k+DISPENSE_COUNT -> done=1 for one cycle after edge k+DISPENSE_COUNT.
- Comparisons use >=, so a count that overshoots (external glitch) still terminates. Width is BIT_COUNT, unsigned, with no wrap handling needed.
- Ignored requests:
  - request edges in any state other than IDLE are ignored and are not queued.
  - A request edge with cup_present=0 is ignored.
  - Holding request high yields one dispense only.
- Simultaneous events:
  - Cup removal in the same cycle as completion yields ABORT, not DONE.
  - done and aborted are never both 1.
- Reset mid-dispense: valve_open drops to 0 on the reset edge, counter_clear goes to 1, and no done/aborted pulse is produced.

Optional Feature:
- Macro: DISPENSE_COOLDOWN_EN.
- Defined:
  - DONE -> COOLDOWN, in which the counter runs from 0.
  - busy stays 1 for COOLDOWN_COUNT cycles after DONE.
  - Requests are ignored during COOLDOWN.
  - cup_present has no effect during COOLDOWN.
- Undefined:
  - The COOLDOWN state and the COOLDOWN_COUNT logic are not built.
  - DONE -> IDLE directly, so a new request is accepted starting with the cycle after DONE.

Test Plan:
1. Reset release with request held at 1 and cup_present=1 -> stays IDLE, valve_open=0, counter_clear=1, no dispense.
2. cup_present=1, one rising request edge, DISPENSE_COUNT=18 -> valve_open high for exactly 18 cycles, count observed 0..17, done pulses 1 cycle, counter_clear=1 afterwards.
3. cup_present drops at DISPENSE cycle 5 -> valve_open=0 next cycle, aborted=1 for 1 cycle, done never asserts, count cleared to 0.
4. Second request edge at DISPENSE cycle 10 -> ignored; exactly one 18-cycle dispense and one done pulse.
5. reset=0 at DISPENSE cycle 7 -> valve_open=0 and counter_clear=1 at that edge, no done/aborted pulse, IDLE afterwards.
6. DISPENSE_COOLDOWN_EN defined, COOLDOWN_COUNT=8 -> busy=1 for 8 cycles after done; a request edge during them is ignored; a request edge after busy falls starts a new 18-cycle dispense.
